// File: rtl/pe_elastic_switch_matrix.sv
// -----------------------------------------------------------------------------
// pe_elastic_switch_matrix
//
// Elastic NUM_IN x NUM_OUT word crossbar placed between the tile's
// directional/register ports and the PE operands of the CGRA fabric. Each
// output selects one input, or none, from its ConfigBits field. Each output
// is buffered by a private FIFO, so a stalled sink does not stall the other
// sinks fed by the same source until that sink's FIFO fills.
//
// An input forks lazily and all-or-nothing. It is ready only when at least
// one enabled output subscribes to it and every subscriber FIFO has room.
// An accepted word is pushed into all subscriber FIFOs in the same cycle.
// in_ready depends only on FIFO occupancy and ConfigBits. There is no
// combinational path from in_valid or out_ready to in_ready.
//
// Ports
//   UserCLK     in   1               fabric clock; all state changes on the rising edge
//   rst         in   1               synchronous, active-high reset
//   in_data     in   NUM_IN*WIDTH    source words; channel i = [i*WIDTH +: WIDTH]
//   in_valid    in   NUM_IN          source valid per channel
//   in_ready    out  NUM_IN          source ready per channel
//   out_data    out  NUM_OUT*WIDTH   FIFO head word per output (0 when empty)
//   out_valid   out  NUM_OUT         FIFO non-empty per output
//   out_ready   in   NUM_OUT         sink ready per output
//   ConfigBits  in   NoConfigBits    output o select = ConfigBits[o*SEL_W +: SEL_W];
//                                    a select value >= NUM_IN disables that output
//   stall_cnt   out  NUM_OUT*16      present only with PE_SM_STALL_CNT_EN defined;
//                                    saturating count of cycles with out_valid & ~out_ready
//
// Optional feature macro: PE_SM_STALL_CNT_EN
// -----------------------------------------------------------------------------
module pe_elastic_switch_matrix #(
   parameter int WIDTH        = 32,
   parameter int NUM_IN       = 9,
   parameter int NUM_OUT      = 8,
   parameter int DEPTH        = 2,
   parameter int SEL_W        = $clog2(NUM_IN + 1),
   parameter int NoConfigBits = NUM_OUT * SEL_W
) (
   input  logic                       UserCLK,
   input  logic                       rst,
   input  logic [NUM_IN*WIDTH-1:0]    in_data,
   input  logic [NUM_IN-1:0]          in_valid,
   output logic [NUM_IN-1:0]          in_ready,
   output logic [NUM_OUT*WIDTH-1:0]   out_data,
   output logic [NUM_OUT-1:0]         out_valid,
   input  logic [NUM_OUT-1:0]         out_ready,
   input  logic [NoConfigBits-1:0]    ConfigBits
`ifdef PE_SM_STALL_CNT_EN
   ,
   output logic [NUM_OUT*16-1:0]      stall_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Select decode
   logic [SEL_W-1:0]  sel [NUM_OUT];
   logic [NUM_OUT-1:0] en;
   logic [NUM_OUT-1:0] full;

   // Fork bookkeeping per input
   logic [NUM_IN-1:0] sub_any;
   logic [NUM_IN-1:0] sub_full;
   logic [NUM_IN-1:0] xfer;

   // Per-output FIFO controls
   logic [NUM_OUT-1:0] push;
   logic [NUM_OUT-1:0] pop;
   logic [WIDTH-1:0]   push_data [NUM_OUT];

   // FIFO state
   logic [WIDTH-1:0] mem_q    [NUM_OUT][DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [NUM_OUT];
   logic [PTR_W-1:0] wr_ptr_d [NUM_OUT];
   logic [PTR_W-1:0] rd_ptr_q [NUM_OUT];
   logic [PTR_W-1:0] rd_ptr_d [NUM_OUT];
   logic [CNT_W-1:0] count_q  [NUM_OUT];
   logic [CNT_W-1:0] count_d  [NUM_OUT];

   // ---------------------------------------------------------------------------
   // Select decode and FIFO status
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written in always_comb is given a default first,
      // so no path through the block leaves it unassigned and no latch is inferred.
      out_valid = '0;
      out_data  = '0;
      en        = '0;
      full      = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         sel[o]       = ConfigBits[o*SEL_W +: SEL_W];
         en[o]        = (sel[o] < SEL_W'(NUM_IN));
         full[o]      = (count_q[o] == CNT_W'(DEPTH));
         out_valid[o] = (count_q[o] != '0);
         // The read mux is gated, so an empty output presents zero rather than stale RAM.
         if (out_valid[o]) begin
            out_data[o*WIDTH +: WIDTH] = mem_q[o][rd_ptr_q[o]];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Lazy fork: an input is ready only if it has subscribers and none is full
   // ---------------------------------------------------------------------------
   always_comb begin
      sub_any  = '0;
      sub_full = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         for (int o = 0; o < NUM_OUT; o++) begin
            if (en[o] && (sel[o] == SEL_W'(i))) begin
               sub_any[i] = 1'b1;
               if (full[o]) begin
                  sub_full[i] = 1'b1;
               end
            end
         end
      end
      in_ready = sub_any & ~sub_full;
      xfer     = in_valid & in_ready;
   end

   // ---------------------------------------------------------------------------
   // Push/pop and next-state for each output FIFO
   // ---------------------------------------------------------------------------
   always_comb begin
      push = '0;
      pop  = out_valid & out_ready;
      for (int o = 0; o < NUM_OUT; o++) begin
         push_data[o] = '0;
         for (int i = 0; i < NUM_IN; i++) begin
            if (en[o] && (sel[o] == SEL_W'(i))) begin
               push[o]      = xfer[i];
               push_data[o] = in_data[i*WIDTH +: WIDTH];
            end
         end
         // A push is only granted when this FIFO was not full, so it never
         // overflows. A full FIFO that pops in the same cycle still refuses the push.
         wr_ptr_d[o] = wr_ptr_q[o] + PTR_W'(push[o]);
         rd_ptr_d[o] = rd_ptr_q[o] + PTR_W'(pop[o]);
         count_d[o]  = count_q[o] + CNT_W'(push[o]) - CNT_W'(pop[o]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples values from before the clock edge, regardless of statement order.
   always_ff @(posedge UserCLK) begin
      if (rst) begin
         for (int o = 0; o < NUM_OUT; o++) begin
            wr_ptr_q[o] <= '0;
            rd_ptr_q[o] <= '0;
            count_q[o]  <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_OUT; o++) begin
            wr_ptr_q[o] <= wr_ptr_d[o];
            rd_ptr_q[o] <= rd_ptr_d[o];
            count_q[o]  <= count_d[o];
         end
      end
   end

   // NOTE: the storage array is deliberately not reset. Zero counts already make
   // every entry unreachable, and omitting the reset keeps the array mappable to RAM.
   always_ff @(posedge UserCLK) begin
      for (int o = 0; o < NUM_OUT; o++) begin
         if (push[o] && !rst) begin
            mem_q[o][wr_ptr_q[o]] <= push_data[o];
         end
      end
   end

`ifdef PE_SM_STALL_CNT_EN
   // ---------------------------------------------------------------------------
   // Per-output saturating stall counters
   // ---------------------------------------------------------------------------
   logic [15:0] stall_q [NUM_OUT];

   always_ff @(posedge UserCLK) begin
      if (rst) begin
         for (int o = 0; o < NUM_OUT; o++) begin
            stall_q[o] <= '0;
         end
      end else begin
         for (int o = 0; o < NUM_OUT; o++) begin
            if (out_valid[o] && !out_ready[o] && (stall_q[o] != 16'hFFFF)) begin
               stall_q[o] <= stall_q[o] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      stall_cnt = '0;
      for (int o = 0; o < NUM_OUT; o++) begin
         stall_cnt[o*16 +: 16] = stall_q[o];
      end
   end
`else
   // Stall counters are not built. The datapath is unchanged.
`endif

endmodule
